uart_transceiver: RTL and testbench

- Full-duplex 8N1 UART serial port.
- Wraps two independent engines, uart_receiver (serial -> byte) and uart_transmitter (byte -> serial), sharing one clock and one reset.
- Sits between a board UART pin pair and the fabric's byte-level logic.
- Bit timing is set by a clocks-per-bit divider parameter. There is no fractional baud and no parity.

---
 rtl/uart_transceiver.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent receive and transmit engines
// sharing one clock, one reset and one clocks-per-bit divider.
`timescale 1ns/1ps

module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP
    } rx_state_e;

    rx_state_e     state_q, state_d;
    logic          meta_q, meta_d, sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;
    logic          cnt_last;

    assign cnt_last = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:    if (!sync_q) state_d = RX_START;
            // A line back high at mid-start is a glitch, not a frame
            RX_START:   if (cnt_q == MID) state_d = sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:    if (cnt_last && idx_q == 3'd7) state_d = RX_STOP;
            RX_STOP:    if (cnt_last) state_d = RX_CLEANUP;
            RX_CLEANUP: state_d = RX_IDLE;
            default:    state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        meta_d  = rx_serial;
        sync_d  = meta_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            RX_START: cnt_d = (cnt_q == MID) ? '0 : cnt_q + 1'b1;
            RX_DATA: begin
                if (cnt_last) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sync_q;
                    idx_d          = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_last) begin
                    cnt_d  = '0;
                    dv_d   = 1'b1;
                    byte_d = shift_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_CLEANUP: cnt_d = '0;
            default:    cnt_d = '0;
        endcase
    end

    assign rx_dv   = dv_q;
    assign rx_byte = byte_q;
endmodule

module uart_transmitter #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_active,
    output logic       tx_serial,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP
    } tx_state_e;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          cnt_last;

    assign cnt_last = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:    if (tx_dv) state_d = TX_START;
            TX_START:   if (cnt_last) state_d = TX_DATA;
            TX_DATA:    if (cnt_last && idx_q == 3'd7) state_d = TX_STOP;
            TX_STOP:    if (cnt_last) state_d = TX_CLEANUP;
            TX_CLEANUP: state_d = TX_IDLE;
            default:    state_d = TX_IDLE;
        endcase
    end

    // Line level follows the current state, so it lags the state by one cycle
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = 1'b1;
        active_d = active_q;
        done_d   = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_dv) begin
                    data_d   = tx_byte;
                    active_d = 1'b1;
                end
            end
            TX_START: begin
                serial_d = 1'b0;
                cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
            end
            TX_DATA: begin
                serial_d = data_q[idx_q];
                if (cnt_last) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_CLEANUP: cnt_d = '0;
            default:    cnt_d = '0;
        endcase
    end

    assign tx_active = active_q;
    assign tx_serial = serial_q;
    assign tx_done   = done_q;
endmodule

module uart_transceiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);
    uart_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .rx_serial (i_Rx_Serial),
        .rx_dv     (o_Rx_DV),
        .rx_byte   (o_Rx_Byte)
    );

    uart_transmitter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .tx_dv     (i_Tx_DV),
        .tx_byte   (i_Tx_Byte),
        .tx_active (o_Tx_Active),
        .tx_serial (o_Tx_Serial),
        .tx_done   (o_Tx_Done)
    );
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: frame-level reference of the 8N1 line,
// directed scenarios plus random bytes in RX, TX, loopback and duplex.
`timescale 1ns/1ps

module tb_uart_transceiver;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       lb = 1'b0;
    logic       rx_in;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_active, tx_serial, tx_done;

    int n_pass = 0;
    int n_chk  = 0;
    int done_cnt = 0;
    logic [7:0] rx_got[$];
    logic [7:0] rx_exp[$];

    assign rx_in = lb ? tx_serial : rx_drv;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx_in),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte),
        .i_Tx_DV     (tx_dv),
        .i_Tx_Byte   (tx_byte),
        .o_Tx_Active (tx_active),
        .o_Tx_Serial (tx_serial),
        .o_Tx_Done   (tx_done)
    );

    always #50 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (rx_dv) rx_got.push_back(rx_byte);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one byte and checks the line at the centre of every bit.
    task automatic send_tx(input logic [7:0] b);
        logic [9:0] f;
        int d0, t;
        bit seen;
        f  = {1'b1, b, 1'b0};
        d0 = done_cnt;
        @(negedge clk);
        tx_byte = b;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        cyc(8);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc(CPB);
            chk($sformatf("tx_bit%0d", i), tx_serial, f[i]);
            chk("tx_active", tx_active, 1);
        end
        t = 8 + 9 * CPB;
        seen = 1'b0;
        while (!seen && t < 11 * CPB) begin
            cyc(1);
            t++;
            if (tx_done) seen = 1'b1;
        end
        chk("tx_done_seen", seen, 1);
        chk("tx_done_time", (t >= 10*CPB-1 && t <= 10*CPB+1), 1);
        cyc(2);
        chk("tx_done_pulses", done_cnt - d0, 1);
        chk("tx_idle", {tx_active, tx_serial}, 2'b01);
    endtask

    task automatic rx_frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            cyc(CPB);
        end
        rx_drv = 1'b1;
        cyc(4);
    endtask

    task automatic drain_rx();
        cyc(4);
        chk("rx_count", rx_got.size(), rx_exp.size());
        while (rx_got.size() > 0 && rx_exp.size() > 0)
            chk("rx_byte", rx_got.pop_front(), rx_exp.pop_front());
        rx_got.delete();
        rx_exp.delete();
    endtask

    initial begin
        logic [7:0] a, c;
        logic [7:0] lbv[3];
        logic [9:0] f;
        int d0, lows;

        cyc(3);
        chk("rst_rx_dv", rx_dv, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_tx_serial", tx_serial, 1);
        chk("rst_tx_done", tx_done, 0);
        rst = 1'b0;
        cyc(5);

        send_tx(8'hAB);

        rx_frame(8'h3F);
        rx_exp.push_back(8'h3F);
        drain_rx();
        cyc(40);
        chk("rx_hold", rx_byte, 8'h3F);

        @(negedge clk);
        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(40);
        chk("glitch_no_dv", rx_got.size(), 0);
        chk("glitch_hold", rx_byte, 8'h3F);
        rx_frame(8'h55);
        rx_exp.push_back(8'h55);
        drain_rx();

        fork
            send_tx(8'h34);
            begin
                cyc(60);
                tx_byte = 8'h12;
                tx_dv   = 1'b1;
                cyc(1);
                tx_dv = 1'b0;
            end
        join
        d0 = done_cnt;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (!tx_serial) lows++;
        end
        chk("busy_no_frame", lows, 0);
        chk("busy_no_done", done_cnt - d0, 0);

        lb = 1'b1;
        cyc(2);
        lbv[0] = 8'h00;
        lbv[1] = 8'hFF;
        lbv[2] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            send_tx(lbv[i]);
            rx_exp.push_back(lbv[i]);
        end
        repeat (6) begin
            a = 8'($urandom);
            send_tx(a);
            rx_exp.push_back(a);
        end
        cyc(20);
        drain_rx();
        lb = 1'b0;
        cyc(2);

        repeat (4) begin
            a = 8'($urandom);
            c = 8'($urandom);
            fork
                send_tx(a);
                rx_frame(c);
            join
            rx_exp.push_back(c);
            drain_rx();
        end

        rx_frame(8'h96);
        rx_exp.push_back(8'h96);
        drain_rx();

        d0 = done_cnt;
        f  = {1'b1, 8'h5A, 1'b0};
        @(negedge clk);
        tx_byte = 8'hC3;
        tx_dv   = 1'b1;
        rx_drv  = 1'b0;
        for (int i = 1; i <= 72; i++) begin
            @(negedge clk);
            if (i == 1) tx_dv = 1'b0;
            rx_drv = f[i / CPB];
        end
        #10 rst = 1'b1;
        #1;
        chk("mid_rst_rx_dv", rx_dv, 0);
        chk("mid_rst_rx_byte", rx_byte, 0);
        chk("mid_rst_tx_active", tx_active, 0);
        chk("mid_rst_tx_serial", tx_serial, 1);
        chk("mid_rst_tx_done", tx_done, 0);
        cyc(3);
        rx_drv = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(200);
        chk("post_rst_no_done", done_cnt - d0, 0);
        chk("post_rst_no_dv", rx_got.size(), 0);
        chk("post_rst_line", tx_serial, 1);

        fork
            send_tx(8'hC3);
            rx_frame(8'hC3);
        join
        rx_exp.push_back(8'hC3);
        drain_rx();
        cyc(30);
        chk("final_hold", rx_byte, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
